// File: rtl/fwd_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_hazard_ctrl
//  Description : Forwarding and load-use hazard controller for a 5-stage
//                RISC-V pipeline. Drives the EX-stage operand mux selects,
//                stalls the front end on load-use hazards and freezes all
//                state while data memory is busy.
//  Revision    : 1.0 - initial release
// ============================================================================
module fwd_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  id_valid_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic                  id_uses_rs1_i,
    input  logic                  id_uses_rs2_i,
    input  logic [REG_ADDR_W-1:0] id_rd_i,
    input  logic                  id_reg_write_i,
    input  logic                  id_mem_read_i,
    input  logic                  mem_busy_i,
    output logic [1:0]            fwd_sel_a_o,
    output logic [1:0]            fwd_sel_b_o,
    output logic                  stall_o,
    output logic                  freeze_o,
    output logic [CNT_W-1:0]      stall_count_o
);

    // Operand mux encodings; 2'b11 is never produced.
    localparam logic [1:0]            SEL_RF    = 2'b00;
    localparam logic [1:0]            SEL_EXMEM = 2'b01;
    localparam logic [1:0]            SEL_MEMWB = 2'b10;
    localparam logic [REG_ADDR_W-1:0] REG_X0    = '0;
    localparam logic [CNT_W-1:0]      CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]      CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    // Destination-register state of the instruction occupying a stage.
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
    } trk_t;

    localparam trk_t TRK_BUBBLE = '0;

    trk_t             ex_q,    ex_d;
    trk_t             mem_q,   mem_d;
    logic [1:0]       sel_a_q, sel_a_d;
    logic [1:0]       sel_b_q, sel_b_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    logic       w_ex_cand;
    logic       w_mem_cand;
    logic       w_ex_hit_rs1;
    logic       w_ex_hit_rs2;
    logic       w_mem_hit_rs1;
    logic       w_mem_hit_rs2;
    logic       w_load_use;
    logic       w_freeze;
    logic       w_stall;
    logic [1:0] w_sel_a;
    logic [1:0] w_sel_b;

    // A stage can only supply a value if it really writes a non-x0 register.
    always_comb begin
        w_ex_cand  = ex_q.valid  && ex_q.reg_write  && (ex_q.rd  != REG_X0);
        w_mem_cand = mem_q.valid && mem_q.reg_write && (mem_q.rd != REG_X0);
    end

    // Per-source match against each stage; unused sources never match.
    always_comb begin
        w_ex_hit_rs1  = w_ex_cand  && id_uses_rs1_i && (id_rs1_i == ex_q.rd);
        w_ex_hit_rs2  = w_ex_cand  && id_uses_rs2_i && (id_rs2_i == ex_q.rd);
        w_mem_hit_rs1 = w_mem_cand && id_uses_rs1_i && (id_rs1_i == mem_q.rd);
        w_mem_hit_rs2 = w_mem_cand && id_uses_rs2_i && (id_rs2_i == mem_q.rd);
    end

    // Load in EX feeding a source in ID cannot be forwarded in time; freeze
    // dominates so no stall is reported while memory is busy.
    always_comb begin
        w_load_use = id_valid_i && ex_q.mem_read && (w_ex_hit_rs1 || w_ex_hit_rs2);
        w_freeze   = mem_busy_i;
        w_stall    = w_load_use && !w_freeze;
    end

    // Select for the instruction about to enter EX; the EX stage holds the
    // newer value, so it wins over MEM.
    always_comb begin
        if (w_ex_hit_rs1) begin
            w_sel_a = SEL_EXMEM;
        end else if (w_mem_hit_rs1) begin
            w_sel_a = SEL_MEMWB;
        end else begin
            w_sel_a = SEL_RF;
        end

        if (w_ex_hit_rs2) begin
            w_sel_b = SEL_EXMEM;
        end else if (w_mem_hit_rs2) begin
            w_sel_b = SEL_MEMWB;
        end else begin
            w_sel_b = SEL_RF;
        end
    end

    // Next-state: advance trackers unless frozen, bubble EX on stall or empty ID.
    always_comb begin
        ex_d    = ex_q;
        mem_d   = mem_q;
        sel_a_d = sel_a_q;
        sel_b_d = sel_b_q;
        cnt_d   = cnt_q;

        if (!w_freeze) begin
            mem_d = ex_q;

            if (w_stall || !id_valid_i) begin
                ex_d    = TRK_BUBBLE;
                sel_a_d = SEL_RF;
                sel_b_d = SEL_RF;
            end else begin
                ex_d.valid     = 1'b1;
                ex_d.rd        = id_rd_i;
                ex_d.reg_write = id_reg_write_i;
                ex_d.mem_read  = id_mem_read_i;
                sel_a_d        = w_sel_a;
                sel_b_d        = w_sel_b;
            end

            if (w_stall && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    // State registers; reset takes precedence over a concurrent freeze.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_q    <= TRK_BUBBLE;
            mem_q   <= TRK_BUBBLE;
            sel_a_q <= SEL_RF;
            sel_b_q <= SEL_RF;
            cnt_q   <= '0;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            sel_a_q <= sel_a_d;
            sel_b_q <= sel_b_d;
            cnt_q   <= cnt_d;
        end
    end

    // Output mapping.
    always_comb begin
        fwd_sel_a_o   = sel_a_q;
        fwd_sel_b_o   = sel_b_q;
        stall_o       = w_stall;
        freeze_o      = w_freeze;
        stall_count_o = cnt_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fwd_hazard_ctrl
//  Description : Self-checking bench for fwd_hazard_ctrl with directed
//                scenarios and randomized instruction streams compared
//                against a behavioural pipeline model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fwd_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst  = 1'b1;
    logic       idv  = 1'b0;
    logic [4:0] rs1  = '0;
    logic [4:0] rs2  = '0;
    logic       u1   = 1'b0;
    logic       u2   = 1'b0;
    logic [4:0] rd   = '0;
    logic       rw   = 1'b0;
    logic       mr   = 1'b0;
    logic       busy = 1'b0;

    logic [1:0]  sa, sb, sa4, sb4;
    logic        st, fr, st4, fr4;
    logic [15:0] cnt;
    logic [3:0]  cnt4;

    fwd_hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst), .id_valid_i(idv),
        .id_rs1_i(rs1), .id_rs2_i(rs2), .id_uses_rs1_i(u1), .id_uses_rs2_i(u2),
        .id_rd_i(rd), .id_reg_write_i(rw), .id_mem_read_i(mr), .mem_busy_i(busy),
        .fwd_sel_a_o(sa), .fwd_sel_b_o(sb), .stall_o(st), .freeze_o(fr),
        .stall_count_o(cnt)
    );

    // Narrow counter instance so saturation is reachable in a short run.
    fwd_hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .id_valid_i(idv),
        .id_rs1_i(rs1), .id_rs2_i(rs2), .id_uses_rs1_i(u1), .id_uses_rs2_i(u2),
        .id_rd_i(rd), .id_reg_write_i(rw), .id_mem_read_i(mr), .mem_busy_i(busy),
        .fwd_sel_a_o(sa4), .fwd_sel_b_o(sb4), .stall_o(st4), .freeze_o(fr4),
        .stall_count_o(cnt4)
    );

    // ---------------- behavioural model ----------------
    typedef struct {
        bit v;
        int rd;
        bit rw;
        bit mr;
    } slot_t;

    slot_t m_ex  = '{v: 1'b0, rd: 0, rw: 1'b0, mr: 1'b0};
    slot_t m_mem = '{v: 1'b0, rd: 0, rw: 1'b0, mr: 1'b0};
    int    m_sa   = 0;
    int    m_sb   = 0;
    int    m_cnt  = 0;
    int    m_cnt4 = 0;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    function automatic bit writes(slot_t s);
        return s.v && s.rw && (s.rd != 0);
    endfunction

    function automatic bit m_stall();
        bit dep;
        dep = (u1 == 1'b1 && int'(rs1) == m_ex.rd) || (u2 == 1'b1 && int'(rs2) == m_ex.rd);
        return (idv == 1'b1) && (busy == 1'b0) && writes(m_ex) && m_ex.mr && dep;
    endfunction

    function automatic int m_sel(bit uses, int rs);
        if (!uses) return 0;
        if (writes(m_ex) && m_ex.rd == rs) return 1;
        if (writes(m_mem) && m_mem.rd == rs) return 2;
        return 0;
    endfunction

    always @(posedge clk) begin
        if (rst == 1'b1) begin
            m_ex   = '{v: 1'b0, rd: 0, rw: 1'b0, mr: 1'b0};
            m_mem  = m_ex;
            m_sa   = 0;
            m_sb   = 0;
            m_cnt  = 0;
            m_cnt4 = 0;
        end else if (busy == 1'b0) begin
            bit s;
            int na;
            int nb;
            s  = m_stall();
            na = m_sel(u1, int'(rs1));
            nb = m_sel(u2, int'(rs2));
            m_mem = m_ex;
            if (s || idv == 1'b0) begin
                m_ex = '{v: 1'b0, rd: 0, rw: 1'b0, mr: 1'b0};
                m_sa = 0;
                m_sb = 0;
            end else begin
                m_ex = '{v: 1'b1, rd: int'(rd), rw: rw, mr: mr};
                m_sa = na;
                m_sb = nb;
            end
            if (s) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt4 < 15) m_cnt4++;
            end
        end
    end

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        else
            n_pass++;
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("sel_a",  {30'd0, sa},   m_sa);
            check("sel_b",  {30'd0, sb},   m_sb);
            check("stall",  {31'd0, st},   {31'd0, m_stall()});
            check("freeze", {31'd0, fr},   {31'd0, busy});
            check("count",  {16'd0, cnt},  m_cnt);
            check("count4", {28'd0, cnt4}, m_cnt4);
        end
    end

    // Drive one decode-stage instruction for the next cycle.
    task automatic issue(bit v, int r1, bit uu1, int r2, bit uu2,
                         int d, bit w, bit m, bit b);
        @(posedge clk);
        #1;
        rst  = 1'b0;
        idv  = v;
        rs1  = 5'(r1);
        u1   = uu1;
        rs2  = 5'(r2);
        u2   = uu2;
        rd   = 5'(d);
        rw   = w;
        mr   = m;
        busy = b;
        #1;
    endtask

    task automatic nop();
        issue(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    bit hold;

    initial begin
        // Reset with random inputs for two edges.
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            rst  = 1'b1;
            idv  = 1'($urandom);
            rs1  = 5'($urandom);
            rs2  = 5'($urandom);
            u1   = 1'($urandom);
            u2   = 1'($urandom);
            rd   = 5'($urandom);
            rw   = 1'($urandom);
            mr   = 1'($urandom);
            busy = 1'($urandom);
        end
        @(posedge clk);
        #1;
        rst  = 1'b0;
        idv  = 1'b0;
        busy = 1'b0;
        #1;
        check("rst_sel_a", {30'd0, sa}, 0);
        check("rst_sel_b", {30'd0, sb}, 0);
        check("rst_count", {16'd0, cnt}, 0);
        check("rst_stall", {31'd0, st}, 0);
        check("rst_freeze", {31'd0, fr}, 0);
        chk_en = 1'b1;

        // ALU back-to-back: add x5 ; sub x8, x5, x6
        issue(1, 0, 0, 0, 0, 5, 1, 0, 0);
        issue(1, 5, 1, 6, 1, 8, 1, 0, 0);
        check("b2b_stall", {31'd0, st}, 0);
        nop();
        check("b2b_sel_a", {30'd0, sa}, 1);
        check("b2b_sel_b", {30'd0, sb}, 0);

        // Distance 2: add x5 ; nop ; use x5
        issue(1, 0, 0, 0, 0, 5, 1, 0, 0);
        nop();
        issue(1, 5, 1, 0, 0, 9, 1, 0, 0);
        nop();
        check("dist2_sel_a", {30'd0, sa}, 2);

        // Priority: add x5 ; add x5 ; use x5
        issue(1, 0, 0, 0, 0, 5, 1, 0, 0);
        issue(1, 0, 0, 0, 0, 5, 1, 0, 0);
        issue(1, 5, 1, 0, 0, 9, 1, 0, 0);
        nop();
        check("prio_sel_a", {30'd0, sa}, 1);

        // Load-use: lw x7 ; add x10, x0, x7
        issue(1, 0, 0, 0, 0, 7, 1, 1, 0);
        issue(1, 0, 0, 7, 1, 10, 1, 0, 0);
        check("lu_stall1", {31'd0, st}, 1);
        issue(1, 0, 0, 7, 1, 10, 1, 0, 0);
        check("lu_stall2", {31'd0, st}, 0);
        nop();
        check("lu_sel_b", {30'd0, sb}, 2);
        check("lu_count", {16'd0, cnt}, 1);

        // x0 writer then x0 reader
        issue(1, 0, 0, 0, 0, 0, 1, 0, 0);
        issue(1, 0, 1, 0, 1, 11, 1, 0, 0);
        check("x0_stall", {31'd0, st}, 0);
        nop();
        check("x0_sel_a", {30'd0, sa}, 0);
        check("x0_sel_b", {30'd0, sb}, 0);
        issue(1, 0, 0, 0, 0, 0, 1, 1, 0);
        issue(1, 0, 1, 0, 1, 11, 1, 0, 0);
        check("x0_load_stall", {31'd0, st}, 0);

        // Unused rs2 that names the load destination
        issue(1, 0, 0, 0, 0, 7, 1, 1, 0);
        issue(1, 7, 0, 7, 0, 12, 1, 0, 0);
        check("unused_stall", {31'd0, st}, 0);
        nop();
        check("unused_sel_b", {30'd0, sb}, 0);

        // Freeze during a load-use stall
        issue(1, 0, 0, 0, 0, 7, 1, 1, 0);
        for (int i = 0; i < 3; i++) begin
            issue(1, 0, 0, 7, 1, 10, 1, 0, 1);
            check("frz_stall", {31'd0, st}, 0);
            check("frz_freeze", {31'd0, fr}, 1);
        end
        issue(1, 0, 0, 7, 1, 10, 1, 0, 0);
        check("frz_release_stall", {31'd0, st}, 1);
        issue(1, 0, 0, 7, 1, 10, 1, 0, 0);
        check("frz_after_stall", {31'd0, st}, 0);
        nop();
        check("frz_sel_b", {30'd0, sb}, 2);
        check("frz_count", {16'd0, cnt}, 2);

        // Repeated load-use pairs drive the narrow counter into saturation
        for (int i = 0; i < 20; i++) begin
            issue(1, 0, 0, 0, 0, 7, 1, 1, 0);
            issue(1, 7, 1, 0, 0, 13, 1, 0, 0);
            issue(1, 7, 1, 0, 0, 13, 1, 0, 0);
        end
        nop();
        check("sat_count4", {28'd0, cnt4}, 15);
        check("sat_count16", {16'd0, cnt}, 22);

        // Randomized instruction stream; the front end holds ID on stall/freeze
        hold = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            rst = ($urandom_range(0, 299) == 0);
            if (!hold) begin
                idv = ($urandom_range(0, 7) != 0);
                rs1 = 5'($urandom_range(0, 7));
                rs2 = 5'($urandom_range(0, 7));
                u1  = ($urandom_range(0, 3) != 0);
                u2  = ($urandom_range(0, 3) != 0);
                rd  = 5'($urandom_range(0, 7));
                rw  = ($urandom_range(0, 3) != 0);
                mr  = ($urandom_range(0, 2) == 0);
            end
            busy = ($urandom_range(0, 9) == 0);
            #1;
            hold = m_stall() || (busy == 1'b1);
        end

        @(posedge clk);
        #1;
        rst  = 1'b0;
        busy = 1'b0;
        idv  = 1'b0;
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fwd_hazard_ctrl.md
# fwd_hazard_ctrl

Forwarding and hazard controller for the 5-stage RISC-V pipeline. It drives the 2-bit select inputs of the two EX-stage operand 3-to-1 muxes. Each mux chooses between the register-file value, the EX/MEM ALU result and the MEM/WB write-back value. The block also detects load-use hazards, stalls the front end for one cycle and counts stall cycles. It sits alongside the ID/EX pipeline register, tracks destination-register state for the EX and MEM stages internally, and holds everything when data memory is busy.

## Interface
- REG_ADDR_W, 5, register address width
- CNT_W, 16, stall-counter width
- CLK  in  1  pipeline clock, rising edge
- RESET  in  1  synchronous, active-high reset
- ID_VALID  in  1  decode stage holds a real instruction
- ID_RS1, ID_RS2  in  REG_ADDR_W  source registers of the decode-stage instruction
- ID_USES_RS1, ID_USES_RS2  in  1  the instruction actually reads that source
- ID_RD  in  REG_ADDR_W  destination of the decode-stage instruction
- ID_REG_WRITE  in  1  decode-stage instruction writes ID_RD
- ID_MEM_READ  in  1  decode-stage instruction is a load
- MEM_BUSY  in  1  data memory not ready; freeze the entire pipeline
- FWD_SEL_A, FWD_SEL_B  out  2  operand mux selects: 00 register file, 01 EX/MEM result, 10 MEM/WB result; 11 never driven
- STALL  out  1  hold PC and IF/ID, insert a bubble into ID/EX
- FREEZE  out  1  hold all pipeline registers
- STALL_COUNT  out  CNT_W  saturating count of load-use stall cycles

## Operation
- Two internal tracker slots, EX_T and MEM_T. Each holds {valid, rd, reg_write, mem_read} for the instruction currently in that stage.
- A tracker is a write candidate only if valid, reg_write and rd != 0. Register x0 is never forwarded or stalled on.
- Load-use hazard (combinational):
  - Condition: ID_VALID and EX_T is a write candidate with mem_read, and EX_T.rd equals a used source (ID_RS1 with ID_USES_RS1, or ID_RS2 with ID_USES_RS2).
  - Response: STALL = 1.
- Select computation for the instruction entering EX, per operand with a used source rs:
  - If EX_T is a write candidate and EX_T.rd == rs, select 01.
  - Else if MEM_T is a write candidate and MEM_T.rd == rs, select 10.
  - Else select 00.
  - An unused source always selects 00. EX_T takes priority over MEM_T, so the newest value wins.
- Update on each edge when FREEZE = 0:
  - MEM_T <= EX_T.
  - If STALL or !ID_VALID: EX_T <= bubble (valid 0) and both selects <= 00.
  - Otherwise: EX_T <= {1, ID_RD, ID_REG_WRITE, ID_MEM_READ} and the selects take their computed values.
  - STALL_COUNT increments when STALL = 1 and saturates at all-ones.
- FREEZE = MEM_BUSY, combinational.
  - While FREEZE = 1, all state holds: trackers, selects and counter.
  - STALL is forced to 0, because the freeze dominates.
- Register-file write-through (WB write and ID read in the same cycle) is the register file's job, not this block's.

## Timing
- Reset (RESET high at an edge): EX_T and MEM_T invalid, FWD_SEL_A = FWD_SEL_B = 00, STALL_COUNT = 0. STALL and FREEZE follow their inputs, so they read 0 once idle.
- FWD_SEL_A/B are registered. Values computed while an instruction is in ID are valid during its entire EX cycle, one cycle of latency.
- STALL and FREEZE are combinational in the same cycle; there is no registered path from inputs to these outputs.
- Load-use sequence:
  - Cycle n: the load is in EX, the dependent instruction is in ID, STALL = 1.
  - n+1: the load is in MEM, a bubble is in EX, the dependent instruction is still in ID and now matches MEM_T.
  - n+2: the dependent instruction is in EX with select 10.
  - Exactly one stall cycle per load-use hazard.
- MEM_BUSY asserted mid-stall: the stall is frozen, not lost. STALL re-evaluates after MEM_BUSY drops, so the total stall count is still 1.
- RESET asserted together with MEM_BUSY: reset wins.

## Test plan
- Reset with random inputs, RESET high for 2 cycles → selects 00, STALL_COUNT 0, STALL 0.
- ALU back-to-back dependency: add x5 in ID, then sub reading rs1 = x5 → FWD_SEL_A = 01 in sub's EX cycle, FWD_SEL_B = 00, no stall.
- Distance-2 dependency and priority:
  - add x5, nop, then use of x5 → select 10.
  - add x5, add x5, then use → select 01, the newest writer wins.
- Load-use: lw x7, then add reading rs2 = x7 → STALL = 1 for exactly 1 cycle, FWD_SEL_B = 10 in add's EX cycle, STALL_COUNT = 1.
- x0 and unused operands:
  - Writer with rd = 0 followed by a reader of x0 → select 00, no stall.
  - lw x7 followed by an instruction with ID_USES_RS2 = 0 and ID_RS2 = 7 → no stall.
- Freeze: MEM_BUSY high for 3 cycles during a load-use stall → selects and trackers hold, STALL = 0 while frozen, one stall cycle after release, STALL_COUNT = 1. Counter preset near max saturates at 0xFFFF.
